// File: rtl/alu_issue_if.sv
// Decode-to-EX issue bus: instruction input handshake plus the decoded
// issue entry presented to the EX stage.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic        out_b_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_illegal;

    modport master (
        output in_valid, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_alu_op, out_b_sel, out_imm,
               out_rs1, out_rs2, out_rd, out_wen, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, flush, out_ready,
        output in_ready, out_valid, out_alu_op, out_b_sel, out_imm,
               out_rs1, out_rs2, out_rd, out_wen, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes OP / OP-IMM / LUI into one registered
// issue entry with a valid/ready skid-free handshake and branch flush.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SEL_B = 4'd8,
        ALU_ILL   = 4'hF
    } alu_op_e;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    alu_op_e     dec_op;
    logic        dec_b_sel;
    logic [31:0] dec_imm;
    logic        dec_ill;
    logic        dec_wen;

    logic        valid_q,   valid_d;
    alu_op_e     alu_op_q,  alu_op_d;
    logic        b_sel_q,   b_sel_d;
    logic [31:0] imm_q,     imm_d;
    logic [4:0]  rs1_q,     rs1_d;
    logic [4:0]  rs2_q,     rs2_d;
    logic [4:0]  rd_q,      rd_d;
    logic        wen_q,     wen_d;
    logic        illegal_q, illegal_d;
    logic        in_ready;
    logic        load;

    assign opcode = bus.in_inst[6:0];
    assign funct3 = bus.in_inst[14:12];
    assign funct7 = bus.in_inst[31:25];

    always_comb begin
        dec_op    = ALU_ILL;
        dec_b_sel = 1'b0;
        dec_imm   = '0;
        dec_ill   = 1'b1;
        unique case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    dec_ill = 1'b0;
                    unique case (funct3)
                        3'b000:  dec_op = ALU_ADD;
                        3'b111:  dec_op = ALU_AND;
                        3'b110:  dec_op = ALU_OR;
                        3'b100:  dec_op = ALU_XOR;
                        3'b001:  dec_op = ALU_SLL;
                        3'b101:  dec_op = ALU_SRL;
                        default: dec_ill = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    dec_ill = 1'b0;
                    unique case (funct3)
                        3'b000:  dec_op = ALU_SUB;
                        3'b101:  dec_op = ALU_SRA;
                        default: dec_ill = 1'b1;
                    endcase
                end
            end
            7'b0010011: begin
                dec_ill = 1'b0;
                dec_imm = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
                unique case (funct3)
                    3'b000:  dec_op = ALU_ADD;
                    3'b111:  dec_op = ALU_AND;
                    3'b110:  dec_op = ALU_OR;
                    3'b100:  dec_op = ALU_XOR;
                    3'b001: begin
                        dec_imm = {27'b0, bus.in_inst[24:20]};
                        if (funct7 == 7'b0000000) dec_op  = ALU_SLL;
                        else                      dec_ill = 1'b1;
                    end
                    3'b101: begin
                        dec_imm = {27'b0, bus.in_inst[24:20]};
                        if (funct7 == 7'b0000000)      dec_op  = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec_op  = ALU_SRA;
                        else                           dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec_ill = 1'b0;
                dec_op  = ALU_SEL_B;
                dec_imm = {bus.in_inst[31:12], 12'b0};
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings must present a clean, canonical entry.
        if (dec_ill) begin
            dec_op  = ALU_ILL;
            dec_imm = '0;
        end else begin
            dec_b_sel = (opcode != 7'b0110011);
        end
    end

    assign dec_wen  = !dec_ill && (bus.in_inst[11:7] != 5'd0);
    assign in_ready = !valid_q || bus.out_ready;
    assign load     = bus.in_valid && in_ready;

    always_comb begin
        alu_op_d  = alu_op_q;
        b_sel_d   = b_sel_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        illegal_d = illegal_q;
        valid_d   = valid_q && !bus.out_ready;
        if (load) begin
            valid_d   = 1'b1;
            alu_op_d  = dec_op;
            b_sel_d   = dec_b_sel;
            imm_d     = dec_imm;
            rs1_d     = bus.in_inst[19:15];
            rs2_d     = bus.in_inst[24:20];
            rd_d      = bus.in_inst[11:7];
            wen_d     = dec_wen;
            illegal_d = dec_ill;
        end
        if (bus.flush) valid_d = 1'b0;
        // Keeps out_illegal low whenever no entry is valid.
        if (!valid_d) illegal_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            alu_op_q  <= ALU_ADD;
            b_sel_q   <= 1'b0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            alu_op_q  <= alu_op_d;
            b_sel_q   <= b_sel_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = valid_q;
    assign bus.out_alu_op  = alu_op_q;
    assign bus.out_b_sel   = b_sel_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_rs1     = rs1_q;
    assign bus.out_rs2     = rs2_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_wen     = wen_q;
    assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage: a queue-based reference of accepted
// instructions plus a table-driven decoder, checked every cycle.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic        bsel;
        logic [31:0] imm;
        logic        wen;
        logic        ill;
    } dec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if bus();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] q[$];
    int op_tab [8] = '{0, 5, -1, -1, 4, 6, 3, 2};
    int imm_tab[8] = '{0, -1, -1, -1, 4, -1, 3, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic dec_t ref_dec(input logic [31:0] w);
        dec_t r;
        int t;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        r = '0;
        r.op = 4'hF;
        r.ill = 1'b1;
        t = -1;
        if (opc == 7'h33) begin
            if (f7 == 7'h00) t = op_tab[f3];
            else if (f7 == 7'h20) t = (f3 == 3'd0) ? 1 : (f3 == 3'd5) ? 7 : -1;
            if (t >= 0) begin r.op = t[3:0]; r.ill = 1'b0; end
        end else if (opc == 7'h13) begin
            if (imm_tab[f3] >= 0) begin
                t = imm_tab[f3];
                r.imm = {{20{w[31]}}, w[31:20]};
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7 == 7'h00) t = (f3 == 3'd1) ? 5 : 6;
                else if (f7 == 7'h20 && f3 == 3'd5) t = 7;
                r.imm = {27'b0, w[24:20]};
            end
            if (t >= 0) begin
                r.op = t[3:0]; r.ill = 1'b0; r.bsel = 1'b1;
            end else begin
                r.imm = '0;
            end
        end else if (opc == 7'h37) begin
            r.op = 4'd8; r.ill = 1'b0; r.bsel = 1'b1;
            r.imm = {w[31:12], 12'b0};
        end
        r.wen = !r.ill && (w[11:7] != 5'd0);
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  f7;
        w = $urandom();
        case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom());
        endcase
        case ($urandom_range(0, 5))
            0: w = {f7, w[24:7], 7'h33};
            1: w = {w[31:7], 7'h13};
            2: w = {f7, w[24:7], 7'h13};
            3: w = {w[31:7], 7'h37};
            4: w = w;
            default: w = {w[31:7], ($urandom_range(0, 1) == 0) ? 7'h6F : 7'h03};
        endcase
        return w;
    endfunction

    // Reference: queue of accepted, not-yet-retired, not-flushed instructions.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (bus.flush) begin
            q.delete();
        end else begin
            logic rdy;
            rdy = (q.size() == 0) || bus.out_ready;
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && rdy) q.push_back(bus.in_inst);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid",   32'(bus.out_valid), 32'd0);
            chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
            chk("rst_wen",     32'(bus.out_wen), 32'd0);
            chk("rst_alu_op",  32'(bus.out_alu_op), 32'd0);
            chk("rst_imm",     bus.out_imm, 32'd0);
            chk("rst_rd",      32'(bus.out_rd), 32'd0);
        end else begin
            chk("in_ready",  32'(bus.in_ready), 32'((q.size() == 0) || bus.out_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                dec_t e;
                logic [31:0] w;
                w = q[0];
                e = ref_dec(w);
                chk("alu_op",  32'(bus.out_alu_op), 32'(e.op));
                chk("b_sel",   32'(bus.out_b_sel), 32'(e.bsel));
                chk("imm",     bus.out_imm, e.imm);
                chk("wen",     32'(bus.out_wen), 32'(e.wen));
                chk("illegal", 32'(bus.out_illegal), 32'(e.ill));
                chk("rs1",     32'(bus.out_rs1), 32'(w[19:15]));
                chk("rs2",     32'(bus.out_rs2), 32'(w[24:20]));
                chk("rd",      32'(bus.out_rd), 32'(w[11:7]));
            end else begin
                chk("idle_illegal", 32'(bus.out_illegal), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_chk(input logic [31:0] inst, input logic [3:0] op, input logic bsel,
                            input logic [31:0] imm, input logic wen, input logic ill);
        bus.in_valid  = 1'b1;
        bus.in_inst   = inst;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("lit_valid",   32'(bus.out_valid), 32'd1);
        chk("lit_alu_op",  32'(bus.out_alu_op), 32'(op));
        chk("lit_b_sel",   32'(bus.out_b_sel), 32'(bsel));
        chk("lit_imm",     bus.out_imm, imm);
        chk("lit_wen",     32'(bus.out_wen), 32'(wen));
        chk("lit_illegal", 32'(bus.out_illegal), 32'(ill));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;

        load_chk(32'h002081B3, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("add_rs1", 32'(bus.out_rs1), 32'd1);
        chk("add_rs2", 32'(bus.out_rs2), 32'd2);
        chk("add_rd",  32'(bus.out_rd), 32'd3);
        load_chk(32'hFFF0C093, 4'd4, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        load_chk(32'h4020D093, 4'd7, 1'b1, 32'h00000002, 1'b1, 1'b0);
        load_chk(32'h123452B7, 4'd8, 1'b1, 32'h12345000, 1'b1, 1'b0);
        chk("lui_rd", 32'(bus.out_rd), 32'd5);
        load_chk(32'h00000033, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        load_chk(32'h0000006F, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
        load_chk(32'h02208033, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);

        // Stall for three cycles, then stream eight instructions back to back.
        load_chk(32'h002081B3, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h00000033;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            step();
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_rd",    32'(bus.out_rd), 32'd3);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_inst = {12'(i + 1), 5'd0, 3'b000, 5'(i + 1), 7'h13};
            step();
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk("stream_rd",    32'(bus.out_rd), 32'(i + 1));
            chk("stream_imm",   bus.out_imm, 32'(i + 1));
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_drained", 32'(bus.out_valid), 32'd0);

        // Flush with a held illegal entry and a simultaneous input.
        load_chk(32'h0000006F, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h002081B3;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid",   32'(bus.out_valid), 32'd0);
        chk("flush_illegal", 32'(bus.out_illegal), 32'd0);

        // Reset pulse mid-stall.
        load_chk(32'h123452B7, 4'd8, 1'b1, 32'h12345000, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_wen",   32'(bus.out_wen), 32'd0);
        chk("rst_mid_imm",   bus.out_imm, 32'd0);
        chk("rst_mid_rd",    32'(bus.out_rd), 32'd0);
        step();
        rst_n = 1'b1;
        load_chk(32'h002081B3, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_inst   = rand_inst();
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 24) == 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 in_valid  input  1  decode-side instruction valid.
REQ-003 in_ready  output  1  stage can accept an instruction this cycle.
REQ-004 in_inst  input  32  RV32I instruction word.
REQ-005 flush  input  1  kill the held instruction and the current input (branch redirect).
REQ-006 out_valid  output  1  EX-side issue valid.
REQ-007 out_ready  input  1  EX stage accepts the issued entry.
REQ-008 out_alu_op  output  4  ALU operation code consumed by the EX-stage ALU result selector.
REQ-009 out_b_sel  output  1  0 = operand B from rs2, 1 = operand B from out_imm.
REQ-010 out_imm  output  32  generated immediate.
REQ-011 out_rs1, out_rs2, out_rd  output  5 each  register indices, inst[19:15], [24:20], [11:7].
REQ-012 out_wen  output  1  register write-back enable.
REQ-013 out_illegal  output  1  instruction not supported by this stage.

Function
REQ-014 ALU codes SHALL be: ADD=4'd0, SUB=4'd1, AND=4'd2, OR=4'd3, XOR=4'd4, SLL=4'd5, SRL=4'd6, SRA=4'd7, SEL_B=4'd8; illegal=4'hF.
REQ-015 Opcode 0110011 (OP), funct7 0000000: funct3 000 ADD, 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL; b_sel=0, imm=0.
REQ-016 OP, funct7 0100000: funct3 000 SUB, 101 SRA; any other funct3/funct7 combination on OP SHALL be illegal.
REQ-017 Opcode 0010011 (OP-IMM): funct3 000 ADD, 111 AND, 110 OR, 100 XOR; imm = sign-extended inst[31:20]; b_sel=1.
REQ-018 OP-IMM shifts: funct3 001 with inst[31:25]=0 -> SLL; 101 with inst[31:25]=0 -> SRL, =0100000 -> SRA; imm = {27'b0, inst[24:20]}; other funct7 values illegal.
REQ-019 Opcode 0110111 (LUI): alu_op SEL_B, b_sel=1, imm = {inst[31:12], 12'b0}.
REQ-020 Any other opcode or funct combination SHALL set illegal=1, alu_op=4'hF, wen=0, b_sel=0, imm=0.
REQ-021 wen=1 for every legal instruction with rd != 0; wen=0 when rd = 0.
REQ-022 in_ready = !out_valid || out_ready (combinational); entry loads when in_valid && in_ready.
REQ-023 Latency one cycle: decoded fields appear on outputs the cycle after load.
REQ-024 While out_valid && !out_ready, all out_* fields SHALL hold unchanged.
REQ-025 Entry retires when out_valid && out_ready; simultaneous retire and load SHALL replace the entry with no bubble.
REQ-026 flush=1: next cycle out_valid=0; flush dominates a simultaneous load or hold; in_ready is still the REQ-022 value, but the accepted instruction is discarded.
REQ-027 Data fields of an invalid entry are don't-care except out_illegal, which SHALL be 0 whenever out_valid=0.

Reset
REQ-028 rst_n low SHALL asynchronously clear out_valid, out_illegal, out_wen, out_b_sel to 0, out_alu_op to 4'd0, out_imm and register indices to 0.
REQ-029 Reset asserted mid-hold SHALL drop the held entry; first load is possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 Load 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, alu_op=0, b_sel=0, rs1=1, rs2=2, rd=3, wen=1.
REQ-031 Load 0xFFF0C093 (xori x1,x1,-1) -> alu_op=4, b_sel=1, imm=0xFFFFFFFF; load 0x4020D093 (srai x1,x1,2) -> alu_op=7, imm=2.
REQ-032 Load 0x123452B7 (lui x5) -> alu_op=8, b_sel=1, imm=0x12345000, rd=5, wen=1; load 0x00000033 (add x0) -> wen=0.
REQ-033 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> back-to-back retire+load, no bubble, stream of 8 instructions exits in order.
REQ-034 Load 0x0000006F (jal) and 0x02208033 (mul) -> out_illegal=1, alu_op=4'hF, wen=0.
REQ-035 flush=1 together with in_valid=1 while an entry is held -> next cycle out_valid=0, out_illegal=0; rst_n pulsed low mid-stall -> out_valid=0 immediately.
